sparse_chunk_loader: RTL and testbench

SPARSE_CHUNK_LOADER -- requirements
Module: sparse_chunk_loader

---
 rtl/sparse_loader_pkg.sv | 22 ++
 rtl/sparse_beat_compactor.sv | 32 +++
 rtl/sparse_chunk_loader.sv | 142 ++++++++++++++
 tb/tb_sparse_chunk_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_loader_pkg.sv
// Shared types and default geometry for the sparse chunk loader.
// Bank-state encoding, default beat count and count widths live here.
package sparse_loader_pkg;

  localparam int MEM_SIZE_DEF = 128;
  localparam int BUS_SIZE_DEF = 8;
  localparam int BEATS        = MEM_SIZE_DEF / BUS_SIZE_DEF;
  localparam int BEAT_CNT_W   = $clog2(BEATS);
  localparam int NZ_CNT_W     = $clog2(MEM_SIZE_DEF) + 1;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  function automatic int beats_of(input int mem_size, input int bus_size);
    return mem_size / bus_size;
  endfunction

endpackage

// File: rtl/sparse_beat_compactor.sv
// Combinational per-beat threshold compare and prefix-sum compaction:
// bytes above the threshold are packed toward byte 0 in position order.
module sparse_beat_compactor
  import sparse_loader_pkg::*;
#(
  parameter  int BUS_SIZE = BUS_SIZE_DEF,
  localparam int PC_W     = $clog2(BUS_SIZE) + 1
) (
  input  logic [BUS_SIZE*8-1:0] bytes_i,
  input  logic [7:0]            thresh_i,
  output logic [BUS_SIZE-1:0]   map_o,
  output logic [BUS_SIZE*8-1:0] nz_bytes_o,
  output logic [PC_W-1:0]       popcount_o
);

  always_comb begin
    int slot;
    // NOTE: every output gets a default before the loop so no latch is inferred.
    map_o      = '0;
    nz_bytes_o = '0;
    slot       = 0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      if (bytes_i[i*8 +: 8] > thresh_i) begin
        map_o[i]                 = 1'b1;
        nz_bytes_o[slot*8 +: 8]  = bytes_i[i*8 +: 8];
        slot                     = slot + 1;
      end
    end
    popcount_o = PC_W'(slot);
  end

endmodule

// File: rtl/sparse_chunk_loader.sv
// Double-banked dense-to-sparse chunk loader: fills one bank while draining the other.
// Optional macro SPARSE_LOADER_STATS_EN exposes the drained bank's nonzero count on nz_count_o.
module sparse_chunk_loader
  import sparse_loader_pkg::*;
#(
  parameter  int MEM_SIZE  = MEM_SIZE_DEF,
  parameter  int BUS_SIZE  = BUS_SIZE_DEF,
  localparam int NUM_BEATS = beats_of(MEM_SIZE, BUS_SIZE),
  localparam int CNT_W     = $clog2(NUM_BEATS),
  localparam int NZ_W      = $clog2(MEM_SIZE) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dense_valid_i,
  output logic                  dense_ready_o,
  input  logic [BUS_SIZE*8-1:0] dense_data_i,
  input  logic [7:0]            thresh_i,
  input  logic                  drain_en_i,
  output logic                  wr_valid_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic                  wr_sel_o,
  output logic [BUS_SIZE-1:0]   sparsemap_o,
  output logic [BUS_SIZE*8-1:0] nonzero_data_o,
  output logic                  chunk_done_o,
  output logic [NZ_W-1:0]       nz_count_o
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam int PC_W  = $clog2(BUS_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  bank_state_t          bank_q [2];
  logic                 fill_ptr_q, drain_ptr_q;
  logic [CNT_W-1:0]     fill_beat_q, drain_beat_q;
  logic [7:0]           thresh_q;
  logic [NZ_W-1:0]      nz_q [2];
  logic [MEM_SIZE-1:0]  map_q [2];
  logic [7:0]           data_q [2][MEM_SIZE];

  logic                 accept, first_beat, draining, last_drain;
  logic [7:0]           eff_thresh;
  logic [NZ_W-1:0]      nz_base;
  logic [BUS_SIZE-1:0]  beat_map;
  logic [BUS_SIZE*8-1:0] beat_nz;
  logic [PC_W-1:0]      beat_pop;

  assign dense_ready_o = !rst_i && (bank_q[fill_ptr_q] == BANK_EMPTY ||
                                    bank_q[fill_ptr_q] == BANK_FILLING);
  assign accept     = dense_valid_i && dense_ready_o;
  // The first beat of a chunk compares against the live threshold it is latching.
  assign first_beat = (bank_q[fill_ptr_q] == BANK_EMPTY);
  assign eff_thresh = first_beat ? thresh_i : thresh_q;
  assign nz_base    = first_beat ? '0 : nz_q[fill_ptr_q];
  assign draining   = (bank_q[drain_ptr_q] == BANK_DRAINING);
  assign last_drain = draining && (drain_beat_q == LAST_BEAT);

  sparse_beat_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
    .bytes_i    (dense_data_i),
    .thresh_i   (eff_thresh),
    .map_o      (beat_map),
    .nz_bytes_o (beat_nz),
    .popcount_o (beat_pop)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_q[0]    <= BANK_EMPTY;
      bank_q[1]    <= BANK_EMPTY;
      nz_q[0]      <= '0;
      nz_q[1]      <= '0;
      fill_ptr_q   <= 1'b0;
      drain_ptr_q  <= 1'b0;
      fill_beat_q  <= '0;
      drain_beat_q <= '0;
      thresh_q     <= '0;
    end else begin
      // NOTE: non-blocking updates let fill and drain read the same pre-edge bank states.
      if (accept) begin
        if (first_beat) thresh_q <= thresh_i;
        nz_q[fill_ptr_q] <= nz_base + NZ_W'(beat_pop);
        if (fill_beat_q == LAST_BEAT) begin
          bank_q[fill_ptr_q] <= BANK_FULL;
          fill_ptr_q         <= ~fill_ptr_q;
          fill_beat_q        <= '0;
        end else begin
          bank_q[fill_ptr_q] <= BANK_FILLING;
          fill_beat_q        <= fill_beat_q + 1'b1;
        end
      end
      if (draining) begin
        if (last_drain) begin
          bank_q[drain_ptr_q] <= BANK_EMPTY;
          drain_ptr_q         <= ~drain_ptr_q;
          drain_beat_q        <= '0;
          if (drain_en_i && bank_q[~drain_ptr_q] == BANK_FULL)
            bank_q[~drain_ptr_q] <= BANK_DRAINING;
        end else begin
          drain_beat_q <= drain_beat_q + 1'b1;
        end
      end else if (drain_en_i && bank_q[drain_ptr_q] == BANK_FULL) begin
        bank_q[drain_ptr_q] <= BANK_DRAINING;
        drain_beat_q        <= '0;
      end
    end
  end

  // NOTE: bank storage is not reset; stale slots are masked on read by the nonzero count.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      map_q[fill_ptr_q][int'(fill_beat_q)*BUS_SIZE +: BUS_SIZE] <= beat_map;
      for (int j = 0; j < BUS_SIZE; j++) begin
        if (j < int'(beat_pop))
          data_q[fill_ptr_q][IDX_W'(int'(nz_base) + j)] <= beat_nz[j*8 +: 8];
      end
    end
  end

  always_comb begin
    sparsemap_o    = '0;
    nonzero_data_o = '0;
    if (draining) begin
      sparsemap_o = map_q[drain_ptr_q][int'(drain_beat_q)*BUS_SIZE +: BUS_SIZE];
      for (int k = 0; k < BUS_SIZE; k++) begin
        if ((int'(drain_beat_q)*BUS_SIZE + k) < int'(nz_q[drain_ptr_q]))
          nonzero_data_o[k*8 +: 8] =
            data_q[drain_ptr_q][IDX_W'(int'(drain_beat_q)*BUS_SIZE + k)];
      end
    end
  end

  assign wr_valid_o   = draining;
  assign wr_count_o   = draining ? drain_beat_q : '0;
  assign wr_sel_o     = draining & drain_ptr_q;
  assign chunk_done_o = last_drain;

`ifdef SPARSE_LOADER_STATS_EN
  assign nz_count_o = draining ? nz_q[drain_ptr_q] : '0;
`else
  assign nz_count_o = '0;
`endif

endmodule

// File: tb/tb_sparse_chunk_loader.sv
// Self-checking bench for sparse_chunk_loader (MEM_SIZE=128, BUS_SIZE=8):
// a chunk-level model predicts every drain beat, plus literal pins on key results.
module tb_sparse_chunk_loader;

`ifdef SPARSE_LOADER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        dense_valid_i = 1'b0;
  logic        dense_ready_o;
  logic [63:0] dense_data_i = '0;
  logic [7:0]  thresh_i = '0;
  logic        drain_en_i = 1'b0;
  logic        wr_valid_o;
  logic [3:0]  wr_count_o;
  logic        wr_sel_o;
  logic [7:0]  sparsemap_o;
  logic [63:0] nonzero_data_o;
  logic        chunk_done_o;
  logic [7:0]  nz_count_o;

  always #5 clk_i = ~clk_i;

  sparse_chunk_loader #(.MEM_SIZE(128), .BUS_SIZE(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .dense_valid_i  (dense_valid_i),
    .dense_ready_o  (dense_ready_o),
    .dense_data_i   (dense_data_i),
    .thresh_i       (thresh_i),
    .drain_en_i     (drain_en_i),
    .wr_valid_o     (wr_valid_o),
    .wr_count_o     (wr_count_o),
    .wr_sel_o       (wr_sel_o),
    .sparsemap_o    (sparsemap_o),
    .nonzero_data_o (nonzero_data_o),
    .chunk_done_o   (chunk_done_o),
    .nz_count_o     (nz_count_o)
  );

  typedef struct {
    logic [7:0]  map;
    logic [63:0] data;
    logic [3:0]  cnt;
    logic        done;
    logic        sel;
    logic [7:0]  nz;
  } exp_beat_t;

  exp_beat_t   exp_q[$];
  exp_beat_t   model_beat0;
  int          model_sel = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  cap_map0;
  logic [63:0] cap_data0;
  logic [7:0]  cap_nz0;
  logic        cap_sel0;
  logic [3:0]  cap_done_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bounded wait expired before the expected event", name);
  endtask

  // Chunk-level model: list the bytes above threshold in position order and slice per beat.
  task automatic push_expected(input logic [1023:0] chunk, input logic [7:0] thr);
    logic [7:0]   nzb[$];
    logic [127:0] mp;
    exp_beat_t    b;
    mp = '0;
    for (int p = 0; p < 128; p++) begin
      if (chunk[p*8 +: 8] > thr) begin
        mp[p] = 1'b1;
        nzb.push_back(chunk[p*8 +: 8]);
      end
    end
    for (int n = 0; n < 16; n++) begin
      b.map  = mp[n*8 +: 8];
      b.data = '0;
      for (int k = 0; k < 8; k++)
        if (n*8 + k < nzb.size()) b.data[k*8 +: 8] = nzb[n*8 + k];
      b.cnt  = 4'(n);
      b.done = (n == 15);
      b.sel  = model_sel[0];
      b.nz   = STATS ? 8'(nzb.size()) : 8'd0;
      if (n == 0) model_beat0 = b;
      exp_q.push_back(b);
    end
    model_sel ^= 1;
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] th);
    int waited = 0;
    dense_data_i  = d;
    thresh_i      = th;
    dense_valid_i = 1'b1;
    while (!dense_ready_o && waited < 2000) begin
      @(negedge clk_i);
      waited++;
    end
    if (waited >= 2000) fail_now("ready_wait");
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic send_chunk(input logic [1023:0] chunk, input logic [7:0] thr,
                            input logic [7:0] thr_after);
    @(negedge clk_i);
    for (int b = 0; b < 16; b++)
      send_beat(chunk[b*64 +: 64], (b == 0) ? thr : thr_after);
    dense_valid_i = 1'b0;
    push_expected(chunk, thr);
  endtask

  task automatic wait_drained(input string name);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && !wr_valid_o) return;
    end
    fail_now(name);
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    dense_valid_i = 1'b0;
    exp_q.delete();
    model_sel = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("ready_after_rst", dense_ready_o, 1);
  endtask

  // Compare process: every cycle, against the model queue.
  always @(negedge clk_i) begin
    if (rst_i) begin
      check("rst_ctl", {dense_ready_o, wr_valid_o, wr_count_o, wr_sel_o, sparsemap_o,
                        chunk_done_o, nz_count_o}, '0);
      check("rst_data", nonzero_data_o, '0);
    end else if (wr_valid_o) begin : cmp
      exp_beat_t e;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got wr_valid_o=1 wr_count_o=%0d, required no drain", wr_count_o);
      end else begin
        e = exp_q.pop_front();
        check("beat_count", wr_count_o, e.cnt);
        check("beat_sel", wr_sel_o, e.sel);
        check("beat_map", sparsemap_o, e.map);
        check("beat_data", nonzero_data_o, e.data);
        check("beat_done", chunk_done_o, e.done);
        check("beat_nz", nz_count_o, e.nz);
        if (wr_count_o == 4'd0) begin
          cap_map0  = sparsemap_o;
          cap_data0 = nonzero_data_o;
          cap_nz0   = nz_count_o;
          cap_sel0  = wr_sel_o;
        end
        if (chunk_done_o) cap_done_cnt = wr_count_o;
      end
    end else begin
      check("idle_done", chunk_done_o, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1023:0] ch, ch2;
    int run, v;
    bit first_done, chk_pending, hit;

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("ready_first_cycle", dense_ready_o, 1);

    // All-zero chunk.
    drain_en_i = 1'b1;
    send_chunk('0, 8'h00, 8'h00);
    wait_drained("drain_zero");
    check("zero_done_cnt", cap_done_cnt, 4'd15);
    check("zero_map0", cap_map0, 8'h00);
    check("zero_nz0", cap_nz0, 8'h00);

    // Sparse first beat: 05,00,07,00,00,00,00,09.
    ch = '0;
    ch[63:0] = {8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h05};
    send_chunk(ch, 8'h00, 8'h00);
    check("model_map0_a", model_beat0.map, 8'h85);
    check("model_data0_a", model_beat0.data, 64'h0000_0000_0009_0705);
    wait_drained("drain_sparse");
    check("sparse_map0", cap_map0, 8'h85);
    check("sparse_data0", cap_data0, 64'h0000_0000_0009_0705);
    check("sparse_nz0", cap_nz0, STATS ? 8'd3 : 8'd0);

    // Threshold 0x10 latched on beat 0; live threshold dropped to 0 afterwards.
    ch = {128{8'h10}};
    ch[31:24] = 8'h11;
    send_chunk(ch, 8'h10, 8'h00);
    check("model_map0_t", model_beat0.map, 8'h08);
    check("model_data0_t", model_beat0.data, 64'h11);
    wait_drained("drain_thresh");
    check("thresh_map0", cap_map0, 8'h08);
    check("thresh_data0", cap_data0, 64'h11);

    // Both banks fill with drain held off, then drain back-to-back.
    do_reset();
    drain_en_i = 1'b0;
    for (int p = 0; p < 128; p++) begin
      ch[p*8 +: 8]  = 8'(p*37 + 11);
      ch2[p*8 +: 8] = 8'(p*53 + 3);
    end
    send_chunk(ch, 8'h80, 8'h80);
    send_chunk(ch2, 8'h40, 8'h40);
    check("ready_low_both_full", dense_ready_o, 0);
    drain_en_i  = 1'b1;
    run         = 0;
    first_done  = 1'b0;
    chk_pending = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (chk_pending) begin
        check("ready_after_done", dense_ready_o, 1);
        chk_pending = 1'b0;
      end
      if (wr_valid_o) begin
        run++;
        if (chunk_done_o && !first_done) begin
          first_done  = 1'b1;
          chk_pending = 1'b1;
        end
      end else if (run > 0) begin
        break;
      end
      @(negedge clk_i);
    end
    check("b2b_run", run, 32);
    check("b2b_sel_last", cap_sel0, 1);
    wait_drained("drain_b2b");

    // Reset in the middle of a drain with the other bank also full.
    drain_en_i = 1'b0;
    send_chunk(ch, 8'h20, 8'h20);
    send_chunk(ch2, 8'h20, 8'h20);
    drain_en_i = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk_i);
      if (wr_valid_o && wr_count_o == 4'd7) hit = 1'b1;
    end
    if (!hit) fail_now("reach_count7");
    #2;
    rst_i = 1'b1;
    exp_q.delete();
    model_sel = 0;
    #1 check("rst_kills_valid", wr_valid_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("ready_after_midrst", dense_ready_o, 1);
    v = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (wr_valid_o) v++;
    end
    check("no_residual", v, 0);
    send_chunk(ch2, 8'h05, 8'h05);
    wait_drained("drain_fresh");
    check("fresh_sel", cap_sel0, 0);

    // Fully dense chunk.
    send_chunk({128{8'hFF}}, 8'h00, 8'h00);
    check("model_nz_full", model_beat0.nz, STATS ? 8'd128 : 8'd0);
    wait_drained("drain_full");
    check("full_nz0", cap_nz0, STATS ? 8'd128 : 8'd0);
    check("full_map0", cap_map0, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
